calc_bcd_addsub: RTL and testbench



---
 rtl/calc_bcd_addsub.sv | 244 ++++++++++++++++++++++++
 tb/tb_calc_bcd_addsub.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_bcd_addsub.sv
// rtl/calc_bcd_addsub.sv - digit-serial signed BCD add/subtract unit with operand alignment
// Optional result normalisation stage enabled by defining CALC_ADDSUB_NORMALISE_EN
module calc_bcd_addsub #(
    parameter int NUM_DIGITS = 8,
    parameter int EXP_W      = $clog2(NUM_DIGITS),
    parameter int NUM_W      = 2 + EXP_W + 4 * NUM_DIGITS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             op_sub_i,
    input  logic [NUM_W-1:0] a_i,
    input  logic [NUM_W-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [NUM_W-1:0] result_o
);

    localparam int SIG_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_FIXUP,
        S_COMP,
`ifdef CALC_ADDSUB_NORMALISE_EN
        S_NORM,
`endif
        S_DONE
    } state_t;

`ifdef CALC_ADDSUB_NORMALISE_EN
    localparam state_t POST_STATE = S_NORM;
`else
    localparam state_t POST_STATE = S_DONE;
`endif

    state_t           state_q, state_d;
    logic [SIG_W-1:0] a_sig_q, a_sig_d;
    logic [SIG_W-1:0] b_sig_q, b_sig_d;
    logic [EXP_W-1:0] exp_a_q, exp_a_d;
    logic [EXP_W-1:0] exp_b_q, exp_b_d;
    logic             sign_q, sign_d;
    logic             err_q, err_d;
    logic             eff_sub_q, eff_sub_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] dig_q, dig_d;

    logic [3:0]       dig_x, dig_y, dig_res;
    logic [4:0]       dig_sum;
    logic             dig_cout;

    // Operand fields of the incoming pair
    logic             a_sign, b_sign, a_err, b_err;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [SIG_W-1:0] a_sig, b_sig;

    assign a_sign = a_i[NUM_W-1];
    assign a_err  = a_i[NUM_W-2];
    assign a_exp  = a_i[SIG_W +: EXP_W];
    assign a_sig  = a_i[SIG_W-1:0];
    assign b_sign = b_i[NUM_W-1];
    assign b_err  = b_i[NUM_W-2];
    assign b_exp  = b_i[SIG_W +: EXP_W];
    assign b_sig  = b_i[SIG_W-1:0];

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    // A zero significand is always reported as positive
    assign result_o    = {sign_q & (|a_sig_q), err_q, exp_a_q, a_sig_q};

    // Shared single-digit BCD adder; COMPLEMENT feeds 9-d of the accumulator with no addend
    always_comb begin
        dig_x = a_sig_q[3:0];
        dig_y = 4'd0;
        if (state_q == S_COMP) begin
            dig_x = 4'd9 - a_sig_q[3:0];
        end else begin
            dig_y = eff_sub_q ? (4'd9 - b_sig_q[3:0]) : b_sig_q[3:0];
        end
        dig_sum  = {1'b0, dig_x} + {1'b0, dig_y} + {4'd0, carry_q};
        dig_cout = (dig_sum > 5'd9);
        dig_res  = dig_cout ? (dig_sum[3:0] - 4'd10) : dig_sum[3:0];
    end

    // Next-state logic; the accumulator a_sig shifts right, taking each result digit at the MSD
    always_comb begin
        state_d   = state_q;
        a_sig_d   = a_sig_q;
        b_sig_d   = b_sig_q;
        exp_a_d   = exp_a_q;
        exp_b_d   = exp_b_q;
        sign_d    = sign_q;
        err_d     = err_q;
        eff_sub_d = eff_sub_q;
        carry_d   = carry_q;
        dig_d     = dig_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    eff_sub_d = a_sign ^ b_sign ^ op_sub_i;
                    carry_d   = 1'b0;
                    dig_d     = '0;
                    if (a_err || b_err) begin
                        a_sig_d = '0;
                        b_sig_d = '0;
                        exp_a_d = '0;
                        exp_b_d = '0;
                        sign_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        a_sig_d = a_sig;
                        b_sig_d = b_sig;
                        exp_a_d = a_exp;
                        exp_b_d = b_exp;
                        sign_d  = a_sign;
                        err_d   = 1'b0;
                        state_d = S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                if (exp_a_q == exp_b_q) begin
                    carry_d = eff_sub_q;
                    dig_d   = '0;
                    state_d = S_ADD;
                end else if (exp_a_q < exp_b_q) begin
                    if (a_sig_q[SIG_W-1 -: 4] == 4'd0) begin
                        a_sig_d = a_sig_q << 4;
                        exp_a_d = exp_a_q + EXP_W'(1);
                    end else begin
                        b_sig_d = b_sig_q >> 4;
                        exp_b_d = exp_b_q - EXP_W'(1);
                    end
                end else begin
                    if (b_sig_q[SIG_W-1 -: 4] == 4'd0) begin
                        b_sig_d = b_sig_q << 4;
                        exp_b_d = exp_b_q + EXP_W'(1);
                    end else begin
                        a_sig_d = a_sig_q >> 4;
                        exp_a_d = exp_a_q - EXP_W'(1);
                    end
                end
            end
            S_ADD: begin
                a_sig_d = {dig_res, a_sig_q[SIG_W-1:4]};
                b_sig_d = b_sig_q >> 4;
                carry_d = dig_cout;
                if (dig_q == LAST_DIG) begin
                    state_d = S_FIXUP;
                end else begin
                    dig_d = dig_q + CNT_W'(1);
                end
            end
            S_FIXUP: begin
                if (!eff_sub_q) begin
                    if (carry_q) begin
                        if (exp_a_q != '0) begin
                            a_sig_d = {4'd1, a_sig_q[SIG_W-1:4]};
                            exp_a_d = exp_a_q - EXP_W'(1);
                            state_d = POST_STATE;
                        end else begin
                            a_sig_d = '0;
                            exp_a_d = '0;
                            sign_d  = 1'b0;
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end
                    end else begin
                        state_d = POST_STATE;
                    end
                end else if (!carry_q) begin
                    // |A| < |B|: the ten's complement recovers the magnitude
                    sign_d  = ~sign_q;
                    carry_d = 1'b1;
                    dig_d   = '0;
                    state_d = S_COMP;
                end else begin
                    state_d = POST_STATE;
                end
            end
            S_COMP: begin
                a_sig_d = {dig_res, a_sig_q[SIG_W-1:4]};
                carry_d = dig_cout;
                if (dig_q == LAST_DIG) begin
                    state_d = POST_STATE;
                end else begin
                    dig_d = dig_q + CNT_W'(1);
                end
            end
`ifdef CALC_ADDSUB_NORMALISE_EN
            S_NORM: begin
                if ((exp_a_q != '0) && (a_sig_q[3:0] == 4'd0)) begin
                    a_sig_d = a_sig_q >> 4;
                    exp_a_d = exp_a_q - EXP_W'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            a_sig_q   <= '0;
            b_sig_q   <= '0;
            exp_a_q   <= '0;
            exp_b_q   <= '0;
            sign_q    <= 1'b0;
            err_q     <= 1'b0;
            eff_sub_q <= 1'b0;
            carry_q   <= 1'b0;
            dig_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_sig_q   <= a_sig_d;
            b_sig_q   <= b_sig_d;
            exp_a_q   <= exp_a_d;
            exp_b_q   <= exp_b_d;
            sign_q    <= sign_d;
            err_q     <= err_d;
            eff_sub_q <= eff_sub_d;
            carry_q   <= carry_d;
            dig_q     <= dig_d;
        end
    end

endmodule

// File: tb/tb_calc_bcd_addsub.sv
// tb/tb_calc_bcd_addsub.sv - self-checking bench for calc_bcd_addsub
module tb_calc_bcd_addsub;

    localparam int ND = 8;
    localparam int EW = 3;
    localparam int NW = 2 + EW + 4 * ND;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          op_sub = 1'b0;
    logic [NW-1:0] a = '0;
    logic [NW-1:0] b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [NW-1:0] result;

    int checks = 0;
    int errors = 0;

    calc_bcd_addsub #(.NUM_DIGITS(ND)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .op_sub_i   (op_sub),
        .a_i        (a),
        .b_i        (b),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result)
    );

    always #5 clk = ~clk;

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [NW-1:0] mk(input logic s, input int e, input longint v);
        logic [NW-1:0] r;
        longint t = v;
        r = '0;
        r[NW-1] = s;
        r[4*ND +: EW] = EW'(e);
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic longint val(input logic [NW-1:0] x);
        longint v = 0;
        for (int i = ND - 1; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
        return v;
    endfunction

    // Reference: integer arithmetic on decoded values following the alignment/carry/borrow rules
    function automatic void model(input logic [NW-1:0] x, input logic [NW-1:0] y, input logic sub,
                                  output logic [NW-1:0] r, output int lat);
        longint va, vb, v, lim;
        int ea, eb, shifts;
        logic s, es;
        lim = pow10(ND);
        if (x[NW-2] || y[NW-2]) begin
            r = '0; r[NW-2] = 1'b1; lat = 1;
            return;
        end
        va = val(x); vb = val(y);
        ea = int'(x[4*ND +: EW]); eb = int'(y[4*ND +: EW]);
        shifts = 0;
        while (ea != eb) begin
            shifts++;
            if (ea < eb) begin
                if (va < lim / 10) begin va = va * 10; ea++; end
                else begin vb = vb / 10; eb--; end
            end else begin
                if (vb < lim / 10) begin vb = vb * 10; eb++; end
                else begin va = va / 10; ea--; end
            end
        end
        es = x[NW-1] ^ y[NW-1] ^ sub;
        s = x[NW-1];
        lat = 1 + shifts + ND + 1 + 1;
        if (!es) begin
            v = va + vb;
            if (v >= lim) begin
                if (ea > 0) begin v = v / 10; ea--; end
                else begin r = '0; r[NW-2] = 1'b1; return; end
            end
        end else begin
            v = va - vb;
            if (v < 0) begin v = -v; s = ~s; lat += ND; end
        end
`ifdef CALC_ADDSUB_NORMALISE_EN
        lat += 1;
        while (ea > 0 && v % 10 == 0) begin v = v / 10; ea--; lat++; end
`endif
        if (v == 0) s = 1'b0;
        r = mk(s, ea, v);
    endfunction

    function automatic logic [NW-1:0] rand_num();
        int nd;
        longint v = 0;
        logic [NW-1:0] r;
        nd = $urandom_range(1, ND);
        for (int i = 0; i < nd; i++) v = v * 10 + longint'($urandom_range(0, 9));
        r = mk(1'($urandom_range(0, 1)), $urandom_range(0, (1 << EW) - 1), v);
        if ($urandom_range(0, 15) == 0) r[NW-2] = 1'b1;
        return r;
    endfunction

    // Presents one operand pair, waits (bounded) for the result and takes it
    task automatic drive_op(input logic [NW-1:0] x, input logic [NW-1:0] y, input logic sub,
                            output logic [NW-1:0] res, output int lat, output bit tmo);
        int n = 0;
        tmo = 1'b0;
        @(negedge clk);
        a = x; b = y; op_sub = sub; in_valid = 1'b1;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 200);
        if (!out_valid) tmo = 1'b1;
        res = result;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    endtask

    task automatic test_directed();
        logic [NW-1:0] xa[8], xb[8], xe[8], r, mr;
        logic xs[8];
        int lat, mlat;
        bit tmo;
        xa[0] = mk(0, 1, 15);       xb[0] = mk(0, 2, 225); xs[0] = 0; xe[0] = mk(0, 2, 375);
        xa[1] = mk(0, 0, 3);        xb[1] = mk(0, 0, 5);   xs[1] = 1; xe[1] = mk(1, 0, 2);
        xa[2] = mk(0, 1, 99999999); xb[2] = mk(0, 1, 1);   xs[2] = 0; xe[2] = mk(0, 0, 10000000);
        xa[3] = mk(0, 0, 99999999); xb[3] = mk(0, 0, 1);   xs[3] = 0; xe[3] = '0;
        xe[3][NW-2] = 1'b1;
`ifdef CALC_ADDSUB_NORMALISE_EN
        xa[4] = mk(1, 2, 125);      xb[4] = mk(0, 2, 125); xs[4] = 0; xe[4] = mk(0, 0, 0);
        xa[5] = mk(0, 2, 125);      xb[5] = mk(0, 2, 75);  xs[5] = 0; xe[5] = mk(0, 0, 2);
`else
        xa[4] = mk(1, 2, 125);      xb[4] = mk(0, 2, 125); xs[4] = 0; xe[4] = mk(0, 2, 0);
        xa[5] = mk(0, 2, 125);      xb[5] = mk(0, 2, 75);  xs[5] = 0; xe[5] = mk(0, 2, 200);
`endif
        xa[6] = mk(0, 3, 42);       xb[6] = mk(1, 1, 7);   xs[6] = 0; xe[6] = '0;
        xa[6][NW-2] = 1'b1;         xe[6][NW-2] = 1'b1;
        xa[7] = mk(1, 0, 5);        xb[7] = mk(1, 0, 3);   xs[7] = 1; xe[7] = mk(1, 0, 2);
        for (int i = 0; i < 8; i++) begin
            drive_op(xa[i], xb[i], xs[i], r, lat, tmo);
            model(xa[i], xb[i], xs[i], mr, mlat);
            checks++;
            if (tmo) begin errors++; $display("FAIL directed_%0d_timeout got=no_out_valid exp=out_valid", i); end
            checks++;
            if (r !== xe[i]) begin errors++; $display("FAIL directed_%0d_result got=%h exp=%h", i, r, xe[i]); end
            checks++;
            if (lat !== mlat) begin errors++; $display("FAIL directed_%0d_latency got=%0d exp=%0d", i, lat, mlat); end
        end
    endtask

    task automatic test_random();
        logic [NW-1:0] x, y, r, mr;
        logic s;
        int lat, mlat;
        bit tmo;
        for (int i = 0; i < 300; i++) begin
            x = rand_num(); y = rand_num(); s = 1'($urandom_range(0, 1));
            if (i % 4 == 0) y[4*ND +: EW] = x[4*ND +: EW];
            drive_op(x, y, s, r, lat, tmo);
            model(x, y, s, mr, mlat);
            checks++;
            if (tmo || r !== mr || lat !== mlat) begin
                errors++;
                $display("FAIL random_%0d a=%h b=%h sub=%b got=%h/%0d exp=%h/%0d tmo=%0d",
                         i, x, y, s, r, lat, mr, mlat, tmo);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [NW-1:0] held;
        int n = 0;
        @(negedge clk);
        a = mk(0, 1, 4321); b = mk(0, 0, 9); op_sub = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (!out_valid) begin errors++; $display("FAIL backpressure_timeout got=no_out_valid exp=out_valid"); end
        held = result;
        checks++;
        if (held !== mk(0, 1, 4231)) begin errors++; $display("FAIL backpressure_value got=%h exp=%h", held, mk(0, 1, 4231)); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold_%0d got=%h/%b/%b exp=%h/1/0", i, result, out_valid, in_ready, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL backpressure_release got=%b exp=1", in_ready); end
    endtask

    task automatic test_reset_mid_add();
        int seen = 0;
        @(negedge clk);
        a = mk(0, 2, 1234); b = mk(0, 2, 5678); op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_add got=%b/%b exp=0/1", out_valid, in_ready);
        end
        for (int i = 0; i < 30; i++) begin @(negedge clk); if (out_valid) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL reset_mid_add_no_result got=%0d exp=0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [NW-1:0] r, mr;
        int lat, mlat;
        bit tmo;
        drive_op(mk(0, 0, 12), mk(0, 0, 30), 1'b0, r, lat, tmo);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL back_to_back_ready got=%b exp=1", in_ready); end
        a = mk(0, 3, 500); b = mk(1, 1, 2); op_sub = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL back_to_back_accept got=%b exp=0", in_ready); end
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid && lat < 200);
        model(mk(0, 3, 500), mk(1, 1, 2), 1'b1, mr, mlat);
        checks++;
        if (result !== mr || lat !== mlat) begin
            errors++; $display("FAIL back_to_back_second got=%h/%0d exp=%h/%0d", result, lat, mr, mlat);
        end
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_add();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
